// File: rtl/sha256_w_scheduler.sv
// SHA-256 message-schedule sequencer: loads one 512-bit block and streams
// W0..W(ROUNDS-1) over a valid/ready handshake using a 16-word sliding window.

module sha256_calculate_w (
    input  logic [511:0] block_w,
    output logic [31:0]  w_t
);
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w9;
    logic [31:0] w14;
    logic [31:0] s0;
    logic [31:0] s1;
    logic        unused_bits;

    // Only W[t], W[t+1], W[t+9], W[t+14] feed the recurrence
    assign unused_bits = ^{block_w[447:224], block_w[191:64], block_w[31:0]};

    always_comb begin
        w0  = block_w[511:480];
        w1  = block_w[479:448];
        w9  = block_w[223:192];
        w14 = block_w[63:32];
        s0  = {w1[6:0], w1[31:7]} ^ {w1[17:0], w1[31:18]} ^ (w1 >> 3);
        s1  = {w14[16:0], w14[31:17]} ^ {w14[18:0], w14[31:19]} ^ (w14 >> 10);
        w_t = s1 + w9 + s0 + w0;
    end
endmodule

module sha256_w_scheduler #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_index,
    output logic         w_last,
    output logic         busy
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_t       state_q;
    state_t       state_d;
    logic [511:0] window_q;
    logic [511:0] window_d;
    logic [5:0]   t_q;
    logic [5:0]   t_d;
    logic [31:0]  w_next;
    logic         run;
    logic         at_last;
    logic         hs;
    logic         load;

    sha256_calculate_w u_calc (
        .block_w (window_q),
        .w_t     (w_next)
    );

    assign run     = (state_q == S_RUN);
    assign at_last = (t_q == LAST_T);
    assign hs      = run & w_ready;

    // Ready may rise in RUN on the final handshake so blocks chain without a gap
    assign blk_ready = !flush & (!run | (at_last & w_ready));
    assign load      = blk_valid & blk_ready;

    assign w_valid = run;
    assign busy    = run;
    assign w_data  = window_q[511:480];
    assign w_index = t_q;
    assign w_last  = run & at_last;

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        t_d      = t_q;
        if (flush) begin
            state_d = S_IDLE;
            t_d     = 6'd0;
        end else if (load) begin
            state_d  = S_RUN;
            window_d = blk_data;
            t_d      = 6'd0;
        end else if (hs) begin
            window_d = {window_q[479:0], w_next};
            if (at_last) begin
                state_d = S_IDLE;
                t_d     = 6'd0;
            end else begin
                t_d = t_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            window_q <= '0;
            t_q      <= 6'd0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            t_q      <= t_d;
        end
    end
endmodule

// File: tb/tb_sha256_w_scheduler.sv
// Randomized self-checking bench for sha256_w_scheduler (64- and 16-round builds)
// against an array-based SHA-256 message schedule model.

module tb_sha256_w_scheduler;
    typedef logic [31:0] sched_t [64];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic [31:0]  w_data;
    logic [5:0]   w_index;
    logic         w_last;
    logic         busy;

    logic         f16 = 1'b0;
    logic         bv16 = 1'b0;
    logic         br16;
    logic [511:0] bd16 = '0;
    logic         wv16;
    logic         wr16 = 1'b0;
    logic [31:0]  wd16;
    logic [5:0]   wi16;
    logic         wl16;
    logic         busy16;

    int checks = 0;
    int failures = 0;

    sched_t       exp_w;
    sched_t       exp_b;
    logic [31:0]  obs [64];
    logic [511:0] abc;
    logic [511:0] b1;
    logic [511:0] b2;

    always #5 clk = ~clk;

    sha256_w_scheduler #(.ROUNDS(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_index(w_index), .w_last(w_last), .busy(busy)
    );

    sha256_w_scheduler #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst(rst), .flush(f16),
        .blk_valid(bv16), .blk_ready(br16), .blk_data(bd16),
        .w_valid(wv16), .w_ready(wr16), .w_data(wd16),
        .w_index(wi16), .w_last(wl16), .busy(busy16)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sched_t model(input logic [511:0] b);
        sched_t w;
        logic [31:0] s0;
        logic [31:0] s1;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32 * i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        return w;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32 * i +: 32] = $urandom;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_blk(input logic [511:0] b);
        blk_valid = 1'b1;
        blk_data  = b;
        #1;
        chk("load_ready", 64'(blk_ready), 64'd1);
        tick();
        blk_valid = 1'b0;
        blk_data  = rand_blk();
    endtask

    // Drains n words from the 64-round DUT with the given w_ready duty (percent)
    task automatic consume(input int n, input int duty);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 4000) begin
            w_ready = ($urandom_range(99) < duty);
            #1;
            chk("w_valid", 64'(w_valid), 64'd1);
            chk("w_index", 64'(w_index), 64'(idx));
            chk("w_data", 64'(w_data), 64'(exp_w[idx]));
            chk("w_last", 64'(w_last), 64'(idx == 63));
            if (w_valid && w_ready) begin
                obs[idx] = w_data;
                idx++;
            end
            tick();
            cyc++;
        end
        w_ready = 1'b0;
        chk("consume_timeout", 64'(idx), 64'(n));
    endtask

    initial begin
        abc = {32'h61626380, 448'h0, 32'h00000018};

        tick();
        tick();
        chk("rst_w_valid", 64'(w_valid), 64'd0);
        chk("rst_w_data", 64'(w_data), 64'd0);
        chk("rst_w_index", 64'(w_index), 64'd0);
        chk("rst_w_last", 64'(w_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_blk_ready", 64'(blk_ready), 64'd1);
        rst = 1'b0;
        tick();

        // "abc" block at full rate
        exp_w = model(abc);
        load_blk(abc);
        consume(64, 100);
        chk("abc_w16", 64'(obs[16]), 64'h61626380);
        chk("abc_w17", 64'(obs[17]), 64'h000F0000);
        chk("abc_w18", 64'(obs[18]), 64'h7DA86405);
        chk("abc_w15", 64'(obs[15]), 64'h00000018);
        chk("abc_idle_valid", 64'(w_valid), 64'd0);
        chk("abc_idle_busy", 64'(busy), 64'd0);
        chk("abc_idle_ready", 64'(blk_ready), 64'd1);

        // Same block under random backpressure
        load_blk(abc);
        consume(64, 50);
        chk("stall_idle_valid", 64'(w_valid), 64'd0);

        // Random block under backpressure
        b1 = rand_blk();
        exp_w = model(b1);
        load_blk(b1);
        consume(64, 60);

        // Back-to-back blocks with blk_valid held high
        b1 = rand_blk();
        b2 = rand_blk();
        exp_w = model(b1);
        exp_b = model(b2);
        blk_valid = 1'b1;
        blk_data  = b1;
        tick();
        blk_data  = b2;
        w_ready   = 1'b1;
        for (int c = 0; c < 128; c++) begin
            #1;
            chk("b2b_valid", 64'(w_valid), 64'd1);
            chk("b2b_index", 64'(w_index), 64'(c % 64));
            chk("b2b_data", 64'(w_data), 64'(c < 64 ? exp_w[c] : exp_b[c-64]));
            chk("b2b_last", 64'(w_last), 64'((c % 64) == 63));
            if (c < 64)
                chk("b2b_ready", 64'(blk_ready), 64'(c == 63));
            tick();
            if (c == 63) begin
                blk_valid = 1'b0;
                blk_data  = rand_blk();
            end
        end
        w_ready = 1'b0;
        chk("b2b_end_valid", 64'(w_valid), 64'd0);

        // Flush at t=20 with a competing block offered
        b1 = rand_blk();
        b2 = rand_blk();
        exp_w = model(b1);
        load_blk(b1);
        consume(20, 100);
        chk("pre_flush_index", 64'(w_index), 64'd20);
        flush     = 1'b1;
        blk_valid = 1'b1;
        blk_data  = b2;
        #1;
        chk("flush_ready", 64'(blk_ready), 64'd0);
        tick();
        flush = 1'b0;
        chk("flush_valid", 64'(w_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        #1;
        chk("post_flush_ready", 64'(blk_ready), 64'd1);
        tick();
        blk_valid = 1'b0;
        exp_w = model(b2);
        consume(64, 70);

        // Asynchronous reset mid-block at t=37
        b1 = rand_blk();
        exp_w = model(b1);
        load_blk(b1);
        consume(37, 100);
        chk("pre_rst_index", 64'(w_index), 64'd37);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(w_valid), 64'd0);
        chk("arst_index", 64'(w_index), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_data", 64'(w_data), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_release_ready", 64'(blk_ready), 64'd1);
        chk("arst_release_valid", 64'(w_valid), 64'd0);
        load_blk(b1);
        consume(64, 100);

        // 16-round build with the "abc" block
        exp_w = model(abc);
        bv16 = 1'b1;
        bd16 = abc;
        #1;
        chk("r16_load_ready", 64'(br16), 64'd1);
        tick();
        bv16 = 1'b0;
        bd16 = '0;
        wr16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("r16_valid", 64'(wv16), 64'd1);
            chk("r16_index", 64'(wi16), 64'(i));
            chk("r16_data", 64'(wd16), 64'(exp_w[i]));
            chk("r16_last", 64'(wl16), 64'(i == 15));
            tick();
        end
        wr16 = 1'b0;
        chk("r16_idle_valid", 64'(wv16), 64'd0);
        chk("r16_idle_busy", 64'(busy16), 64'd0);
        chk("r16_idle_ready", 64'(br16), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
